uart_rx_bit_sampler: RTL and testbench
======================================

// Module: uart_rx_bit_sampler
// PURPOSE
//  Oversampling bit-recovery stage of the UART receiver; sits directly upstream of the
//  RX deserializer. Synchronises the raw rx line and tracks the edge position within the
//  current bit and the bit index within the frame. Takes a 3-sample majority vote at
//  mid-bit and emits one sampled bit per bit period with a single-cycle valid strobe.
//  The RX FSM consumes edge_cnt_out/bit_cnt_out/bit_done_out and drives enable_in.
// PARAMETERS
//  PRESC_W   6  width of prescale_in and edge_cnt_out (supports prescale up to 32)
//  BIT_CNT_W 4  width of bit_cnt_out (frame of up to 12 bits incl. start/parity/stop)
// PORTS
//  clk              in   1          oversampling clock (prescale x baud)
//  reset_n          in   1          asynchronous, active-low reset
//  enable_in        in   1          1 = counting/sampling active (from RX FSM)
//  rx_in            in   1          raw serial line, asynchronous to clk, idle high
//  prescale_in      in   PRESC_W    oversampling ratio; legal values 8, 16, 32
//  sampled_bit_out  out  1          majority-voted value of the current bit
//  sample_valid_out out  1          1-cycle strobe: sampled_bit_out just updated
//  edge_cnt_out     out  PRESC_W    clk edge index within current bit, 0..P-1
//  bit_cnt_out      out  BIT_CNT_W  bit index within frame
//  bit_done_out     out  1          high while edge_cnt_out == P-1 and enable_in
// BEHAVIOUR
//  - Reset (async, reset_n=0): sync flops=1, sample regs s0..s2=1, sampled_bit_out=1,
//    sample_valid_out=0, edge_cnt_out=0, bit_cnt_out=0; bit_done_out therefore 0.
//  - rx_in -> 2-flop synchroniser -> rx_s; 2-cycle latency from rx_in to rx_s.
//  - Effective prescale P = prescale_in if in {8,16,32}, else 8. prescale_in must be
//    stable while enable_in=1; a change mid-frame has undefined sample timing.
//  - MID = P/2. All compares use registered edge_cnt_out.
//  - enable_in=0: next edge clears edge_cnt_out and bit_cnt_out, sample_valid_out=0;
//    sampled_bit_out and s0..s2 hold. Partial-bit samples are discarded.
//  - enable_in=1, per edge: edge_cnt_out==P-1 -> edge_cnt 0, bit_cnt+1 (wraps mod
//    2^BIT_CNT_W, no saturation); otherwise edge_cnt+1.
//  - Sampling: edge_cnt==MID-1 -> s0<=rx_s; ==MID -> s1<=rx_s; ==MID+1 -> s2<=rx_s;
//    ==MID+2 -> sampled_bit_out<=maj(s0,s1,s2), sample_valid_out<=1 (exactly one cycle,
//    i.e. high while edge_cnt_out==MID+3). Any other edge: sample_valid_out<=0.
//  - maj = (s0&s1)|(s1&s2)|(s0&s2). Exactly one valid strobe per complete bit period.
//  - bit_done_out = enable_in & (edge_cnt_out==P-1); combinational decode of registers.
//  - enable_in falling on the edge that would set sample_valid: strobe suppressed.
//  - reset_n asserted mid-bit: all state clears immediately (async); counting restarts
//    at edge 0 on the first edge with reset_n=1 and enable_in=1.
// TESTING
//  1 P=8, rx_in=0 held, enable=1 for 24 clk -> valid strobes at edge_cnt 7 of bits 0,1,2;
//    sampled_bit=0; bit_done every 8th clk; bit_cnt 0->1->2->3.
//  2 P=16, rx_s low only at edge 8 (1 glitch sample) -> sampled_bit=1, one strobe.
//  3 P=16, rx_s low at edges 7,8, high at 9 -> sampled_bit=0; strobe at edge_cnt 11.
//  4 P=8, drop enable at edge_cnt 5 -> next edge edge_cnt=0, bit_cnt=0, no strobe;
//    sampled_bit_out keeps previous value.
//  5 P=32, frame 0,0xA5 LSB-first,1 at baud -> 10 strobes, bits 0,1,0,1,0,0,1,0,1,1;
//    chained deserializer yields 0xA5.
//  6 P=16, reset_n pulse at edge_cnt 9 of bit 3 -> all outputs reset values same cycle;
//    prescale_in=12 afterwards -> strobe period 8 clk (fallback P=8).

Source files
------------

// File: rtl/uart_rx_bit_sampler_if.sv
// -----------------------------------------------------------------------------
// uart_rx_bit_sampler_if
//   Connection between the RX FSM (master) and the oversampling bit sampler
//   (slave).
//
//   enable_in        master -> slave  counting/sampling active
//   rx_in            master -> slave  raw serial line, asynchronous to clk
//   prescale_in      master -> slave  oversampling ratio (8, 16 or 32)
//   sampled_bit_out  slave -> master  majority-voted value of the current bit
//   sample_valid_out slave -> master  1-cycle strobe: sampled_bit_out updated
//   edge_cnt_out     slave -> master  clk edge index within the current bit
//   bit_cnt_out      slave -> master  bit index within the frame
//   bit_done_out     slave -> master  last edge of the current bit
// -----------------------------------------------------------------------------
interface uart_rx_bit_sampler_if #(
  parameter int PRESC_W   = 6,
  parameter int BIT_CNT_W = 4
);
  logic                 enable_in;
  logic                 rx_in;
  logic [PRESC_W-1:0]   prescale_in;
  logic                 sampled_bit_out;
  logic                 sample_valid_out;
  logic [PRESC_W-1:0]   edge_cnt_out;
  logic [BIT_CNT_W-1:0] bit_cnt_out;
  logic                 bit_done_out;

  modport master (
    output enable_in, rx_in, prescale_in,
    input  sampled_bit_out, sample_valid_out, edge_cnt_out, bit_cnt_out,
           bit_done_out
  );

  modport slave (
    input  enable_in, rx_in, prescale_in,
    output sampled_bit_out, sample_valid_out, edge_cnt_out, bit_cnt_out,
           bit_done_out
  );
endinterface

// File: rtl/uart_rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_bit_sampler
//   Oversampling bit-recovery stage of the UART receiver. Synchronises the raw
//   rx line, tracks the edge position within the current bit and the bit index
//   within the frame, takes a 3-sample majority vote around mid-bit and emits
//   one sampled bit per bit period with a single-cycle valid strobe.
//
//   clk      in  oversampling clock (prescale x baud)
//   reset_n  in  asynchronous, active-low reset
//   bus      slave side of uart_rx_bit_sampler_if (see interface header)
// -----------------------------------------------------------------------------
module uart_rx_bit_sampler #(
  parameter int PRESC_W   = 6,
  parameter int BIT_CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  uart_rx_bit_sampler_if.slave   bus
);

  // ---------------------------------------------------------------------------
  // rx synchroniser. Both stages reset to the idle-high line level so a frame
  // is never falsely started out of reset.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  // NOTE: every sequential block uses non-blocking assignments so all flops
  // update together at the edge; blocking here would collapse the two
  // synchroniser stages into one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx_in;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Effective prescale and decode points. Unsupported ratios fall back to 8 so
  // the counter always wraps at a power of two the voting window fits into.
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0]   p_eff;
  logic [PRESC_W-1:0]   last_edge;
  logic [PRESC_W-1:0]   mid;
  logic                 at_last;
  logic                 at_s0;
  logic                 at_s1;
  logic                 at_s2;
  logic                 at_vote;

  // NOTE: the combinational block assigns p_eff a default before any
  // condition, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    p_eff = PRESC_W'(8);
    if (bus.prescale_in == PRESC_W'(16) || bus.prescale_in == PRESC_W'(32)) begin
      p_eff = bus.prescale_in;
    end
  end

  assign last_edge = p_eff - PRESC_W'(1);
  assign mid       = p_eff >> 1;

  logic [PRESC_W-1:0]   edge_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // All decodes look at the registered edge count.
  assign at_last = (edge_cnt == last_edge);
  assign at_s0   = (edge_cnt == mid - PRESC_W'(1));
  assign at_s1   = (edge_cnt == mid);
  assign at_s2   = (edge_cnt == mid + PRESC_W'(1));
  assign at_vote = (edge_cnt == mid + PRESC_W'(2));

  // ---------------------------------------------------------------------------
  // Counters, sample registers and the voted output
  // ---------------------------------------------------------------------------
  logic s0;
  logic s1;
  logic s2;
  logic sampled_bit;
  logic sample_valid;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      s0           <= 1'b1;
      s1           <= 1'b1;
      s2           <= 1'b1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else if (!bus.enable_in) begin
      // Abandon any partial bit; the last voted bit and samples are kept.
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (at_last) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);  // wraps, no saturation
      end else begin
        edge_cnt <= edge_cnt + PRESC_W'(1);
      end

      if (at_s0) s0 <= rx_s;
      if (at_s1) s1 <= rx_s;
      if (at_s2) s2 <= rx_s;

      // Strobe is high for exactly the cycle edge_cnt sits at MID+3.
      sample_valid <= at_vote;
      if (at_vote) begin
        sampled_bit <= maj3(s0, s1, s2);
      end
    end
  end

  assign bus.edge_cnt_out     = edge_cnt;
  assign bus.bit_cnt_out      = bit_cnt;
  assign bus.sampled_bit_out  = sampled_bit;
  assign bus.sample_valid_out = sample_valid;
  assign bus.bit_done_out     = bus.enable_in & at_last;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_bit_sampler
//   Self-checking bench for uart_rx_bit_sampler: a table of per-cycle vectors
//   for steady P=8 reception and enable drops, plus hand-written sequences for
//   glitch rejection, majority voting, a full P=32 frame and mid-bit reset with
//   prescale fallback.
// -----------------------------------------------------------------------------
module tb_uart_rx_bit_sampler;

  localparam int PRESC_W   = 6;
  localparam int BIT_CNT_W = 4;

  logic clk = 1'b0;
  logic reset_n;

  uart_rx_bit_sampler_if #(.PRESC_W(PRESC_W), .BIT_CNT_W(BIT_CNT_W)) bus ();

  uart_rx_bit_sampler #(.PRESC_W(PRESC_W), .BIT_CNT_W(BIT_CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic en;
    logic rx;
    int   exp_edge;
    int   exp_bitn;
    int   exp_valid;
    int   exp_sampled;
    int   exp_done;
  } vec_t;

  vec_t vecs[64];
  int   nvec;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input int e_edge, input int e_bitn,
                           input int e_valid, input int e_sampled, input int e_done);
    check($sformatf("%s edge_cnt", tag), int'(bus.edge_cnt_out), e_edge);
    check($sformatf("%s bit_cnt", tag), int'(bus.bit_cnt_out), e_bitn);
    check($sformatf("%s valid", tag), int'(bus.sample_valid_out), e_valid);
    check($sformatf("%s sampled", tag), int'(bus.sampled_bit_out), e_sampled);
    check($sformatf("%s bit_done", tag), int'(bus.bit_done_out), e_done);
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic rx, input int e, input int b,
                              input int v, input int s, input int d);
    vec_t r;
    r.en = en; r.rx = rx; r.exp_edge = e; r.exp_bitn = b;
    r.exp_valid = v; r.exp_sampled = s; r.exp_done = d;
    return r;
  endfunction

  // One bit period at prescale p with bench-tracked edge e starting at 0.
  // low_mask bit k = 1 makes the synchronised line low while edge_cnt == k;
  // rx_in is driven two edges early to cover the synchroniser latency.
  task automatic run_bit(input string tag, input int p, input logic [31:0] low_mask,
                         input int exp_sampled);
    int e = 0;
    int strobes = 0;
    bus.enable_in = 1'b1;
    for (int i = 0; i < p; i++) begin
      bus.rx_in = low_mask[(e + 2) % p] ? 1'b0 : 1'b1;
      tick();
      e = (e + 1) % p;
      if (bus.sample_valid_out) begin
        strobes++;
        check($sformatf("%s strobe edge", tag), int'(bus.edge_cnt_out), p / 2 + 3);
        check($sformatf("%s sampled", tag), int'(bus.sampled_bit_out), exp_sampled);
      end
    end
    check($sformatf("%s strobe count", tag), strobes, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] frame;
    logic [9:0]  sr;
    int          nstrobe;
    int          prev_t;

    // ---------------- reset ----------------
    reset_n          = 1'b0;
    bus.enable_in    = 1'b0;
    bus.rx_in        = 1'b1;
    bus.prescale_in  = 6'd8;
    tick();
    tick();
    check_all("reset", 0, 0, 0, 1, 0);
    #1 reset_n = 1'b1;

    // ---------------- vector table ----------------
    // Test 1: P=8, rx held low, 24 enabled clocks.
    nvec = 0;
    for (int j = 0; j < 24; j++) begin
      vecs[nvec++] = mk(1'b1, 1'b0, (j + 1) % 8, (j + 1) / 8,
                        ((j + 1) % 8 == 7) ? 1 : 0,
                        (j >= 6) ? 0 : 1,
                        ((j + 1) % 8 == 7) ? 1 : 0);
    end
    // Test 4: rx high now; drop enable at edge 5 -> counters clear, no strobe.
    vecs[nvec++] = mk(1'b1, 1'b1, 1, 3, 0, 0, 0);
    vecs[nvec++] = mk(1'b1, 1'b1, 2, 3, 0, 0, 0);
    vecs[nvec++] = mk(1'b1, 1'b1, 3, 3, 0, 0, 0);
    vecs[nvec++] = mk(1'b1, 1'b1, 4, 3, 0, 0, 0);
    vecs[nvec++] = mk(1'b1, 1'b1, 5, 3, 0, 0, 0);
    vecs[nvec++] = mk(1'b0, 1'b1, 0, 0, 0, 0, 0);
    // Enable falls on the edge that would raise the strobe: suppressed.
    vecs[nvec++] = mk(1'b1, 1'b1, 1, 0, 0, 0, 0);
    vecs[nvec++] = mk(1'b1, 1'b1, 2, 0, 0, 0, 0);
    vecs[nvec++] = mk(1'b1, 1'b1, 3, 0, 0, 0, 0);
    vecs[nvec++] = mk(1'b1, 1'b1, 4, 0, 0, 0, 0);
    vecs[nvec++] = mk(1'b1, 1'b1, 5, 0, 0, 0, 0);
    vecs[nvec++] = mk(1'b1, 1'b1, 6, 0, 0, 0, 0);
    vecs[nvec++] = mk(1'b0, 1'b1, 0, 0, 0, 0, 0);

    // Let rx=0 settle through the synchroniser before counting.
    bus.rx_in = 1'b0;
    tick(); tick(); tick();

    for (int i = 0; i < nvec; i++) begin
      bus.enable_in = vecs[i].en;
      bus.rx_in     = vecs[i].rx;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_edge, vecs[i].exp_bitn,
                vecs[i].exp_valid, vecs[i].exp_sampled, vecs[i].exp_done);
    end

    // ---------------- test 2: single glitch sample, P=16 ----------------
    bus.enable_in   = 1'b0;
    bus.rx_in       = 1'b1;
    bus.prescale_in = 6'd16;
    tick(); tick(); tick();
    run_bit("glitch", 16, 32'h0000_0100, 1);

    // ---------------- test 3: two low samples out of three ----------------
    bus.enable_in = 1'b0;
    bus.rx_in     = 1'b1;
    tick(); tick(); tick();
    run_bit("majority", 16, 32'h0000_0180, 0);

    // ---------------- test 5: full frame at P=32 ----------------
    bus.enable_in   = 1'b0;
    bus.rx_in       = 1'b1;
    bus.prescale_in = 6'd32;
    tick(); tick(); tick();
    frame   = {2'b11, 8'hA5, 1'b0};  // idle, stop, data LSB-first, start
    sr      = '0;
    nstrobe = 0;
    bus.enable_in = 1'b1;
    for (int t = 0; t < 320; t++) begin
      bus.rx_in = frame[(t + 2) / 32];
      tick();
      if (bus.sample_valid_out) begin
        check("frame strobe edge", int'(bus.edge_cnt_out), 19);
        if (nstrobe < 10) begin
          check($sformatf("frame bit%0d", nstrobe), int'(bus.sampled_bit_out),
                int'(frame[nstrobe]));
        end
        sr = {bus.sampled_bit_out, sr[9:1]};
        nstrobe++;
      end
    end
    check("frame strobe count", nstrobe, 10);
    check("frame byte", int'(sr[8:1]), 8'hA5);
    check("frame start bit", int'(sr[0]), 0);
    check("frame stop bit", int'(sr[9]), 1);
    check("frame bit_cnt", int'(bus.bit_cnt_out), 10);

    // ---------------- test 6: mid-bit reset, then prescale fallback ----------------
    bus.enable_in   = 1'b0;
    bus.rx_in       = 1'b0;
    bus.prescale_in = 6'd16;
    tick(); tick(); tick();
    bus.enable_in = 1'b1;
    for (int i = 0; i < 57; i++) tick();
    check("pre-reset edge_cnt", int'(bus.edge_cnt_out), 9);
    check("pre-reset bit_cnt", int'(bus.bit_cnt_out), 3);
    check("pre-reset sampled", int'(bus.sampled_bit_out), 0);
    reset_n = 1'b0;
    #1;
    check_all("async reset", 0, 0, 0, 1, 1'b0);
    #1 reset_n = 1'b1;
    bus.prescale_in = 6'd12;
    nstrobe = 0;
    prev_t  = -1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 8) check("fallback wrap edge_cnt", int'(bus.edge_cnt_out), 0);
      if (bus.sample_valid_out) begin
        check("fallback strobe edge", int'(bus.edge_cnt_out), 7);
        check("fallback sampled", int'(bus.sampled_bit_out), 0);
        if (prev_t >= 0) check("fallback strobe period", i - prev_t, 8);
        prev_t = i;
        nstrobe++;
      end
    end
    check("fallback strobe count", nstrobe, 3);
    check("fallback bit_cnt", int'(bus.bit_cnt_out), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
